// File: rtl/l1icache_assoc_if.sv
// Fetch-side and MMU-side signals of the set-associative L1 instruction cache.
// The cache connects through the slave modport; the IF stage / MMU side uses master.
interface l1icache_assoc_if #(
    parameter int LINE_BYTES = 32
);
    logic                    l1_read;
    logic [31:0]             l1_addr;
    logic                    l1_is_mmio;
    logic [31:0]             l1_data_o;
    logic                    hit;
    logic                    stall;
    logic                    l1_mmu_req_read;
    logic [31:0]             l1_mmu_req_addr;
    logic                    mmu_l1_done;
    logic [LINE_BYTES*8-1:0] mmu_l1_read_data;
    logic                    sync;

    modport slave (
        input  l1_read, l1_addr, l1_is_mmio, mmu_l1_done, mmu_l1_read_data, sync,
        output l1_data_o, hit, stall, l1_mmu_req_read, l1_mmu_req_addr
    );

    modport master (
        output l1_read, l1_addr, l1_is_mmio, mmu_l1_done, mmu_l1_read_data, sync,
        input  l1_data_o, hit, stall, l1_mmu_req_read, l1_mmu_req_addr
    );
endinterface

// File: rtl/l1icache_assoc.sv
// Set-associative L1 instruction cache: zero-cycle hits, line refill from the MMU on a miss,
// uncached MMIO fetches and a whole-cache invalidate walk used for reset and fence.i.
module l1icache_assoc #(
    parameter int WAYS       = 2,
    parameter int SETS       = 512,
    parameter int LINE_BYTES = 32
) (
    input  logic             sys_clk,
    input  logic             rst,
    l1icache_assoc_if.slave  bus
);
    localparam int OFF_W     = $clog2(LINE_BYTES);
    localparam int IDX_W     = $clog2(SETS);
    localparam int TAG_W     = 32 - IDX_W - OFF_W;
    localparam int WAY_W     = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam int WORD_W    = OFF_W - 2;
    localparam int LINE_BITS = LINE_BYTES * 8;

    typedef enum logic [2:0] {
        S_FLUSH,
        S_IDLE,
        S_REFILL,
        S_MMIO,
        S_MMIO_RESP
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [SETS-1:0]      valid_q [WAYS];
    logic [TAG_W-1:0]     tag_q   [WAYS][SETS];
    logic [LINE_BITS-1:0] data_q  [WAYS][SETS];
    logic [WAY_W-1:0]     rr_q    [SETS];

    logic [IDX_W-1:0]  flush_cnt_q;
    logic [TAG_W-1:0]  miss_tag_q;
    logic [IDX_W-1:0]  miss_idx_q;
    logic [WAY_W-1:0]  miss_way_q;
    logic [31:0]       mmio_buf_q;
    logic              req_read_q;
    logic [31:0]       req_addr_q;
    logic              sync_pending_q;

    logic [IDX_W-1:0]     lu_idx;
    logic [TAG_W-1:0]     lu_tag;
    logic [WORD_W-1:0]    lu_word;
    logic [WAYS-1:0]      way_match;
    logic                 any_match;
    logic [WAY_W-1:0]     hit_way;
    logic [WAY_W-1:0]     victim_way;
    logic [LINE_BITS-1:0] hit_line;
    logic [31:0]          hit_word;

    logic start_refill;
    logic start_mmio;
    logic refill_wr;
    logic mmio_wr;
    logic busy;
    logic enter_flush;
    logic flush_restart;

    assign lu_idx  = bus.l1_addr[OFF_W +: IDX_W];
    assign lu_tag  = bus.l1_addr[31 -: TAG_W];
    assign lu_word = bus.l1_addr[2 +: WORD_W];

    // Victim preference: lowest-index invalid way, otherwise the set's round-robin pointer.
    always_comb begin
        way_match  = '0;
        hit_way    = '0;
        victim_way = rr_q[lu_idx];
        for (int w = 0; w < WAYS; w++) begin
            way_match[w] = valid_q[w][lu_idx] && (tag_q[w][lu_idx] == lu_tag);
        end
        for (int w = 0; w < WAYS; w++) begin
            if (way_match[w]) begin
                hit_way = WAY_W'(w);
            end
        end
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!valid_q[w][lu_idx]) begin
                victim_way = WAY_W'(w);
            end
        end
    end

    assign any_match = |way_match;
    assign hit_line  = data_q[hit_way][lu_idx];
    assign hit_word  = hit_line[{lu_word, 5'b00000} +: 32];

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state_q <= S_FLUSH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        bus.stall     = 1'b0;
        bus.hit       = 1'b0;
        bus.l1_data_o = '0;
        start_refill  = 1'b0;
        start_mmio    = 1'b0;
        refill_wr     = 1'b0;
        mmio_wr       = 1'b0;
        case (state_q)
            S_FLUSH: begin
                bus.stall = bus.l1_read;
                if (!bus.sync && (flush_cnt_q == IDX_W'(SETS - 1))) begin
                    state_d = S_IDLE;
                end
            end
            S_IDLE: begin
                if (bus.sync) begin
                    bus.stall = bus.l1_read;
                    state_d   = S_FLUSH;
                end else if (bus.l1_read) begin
                    if (bus.l1_is_mmio) begin
                        bus.stall  = 1'b1;
                        start_mmio = 1'b1;
                        state_d    = S_MMIO;
                    end else if (any_match) begin
                        bus.hit       = 1'b1;
                        bus.l1_data_o = hit_word;
                    end else begin
                        bus.stall    = 1'b1;
                        start_refill = 1'b1;
                        state_d      = S_REFILL;
                    end
                end
            end
            S_REFILL: begin
                bus.stall = bus.l1_read;
                if (bus.mmu_l1_done) begin
                    refill_wr = 1'b1;
                    state_d   = (sync_pending_q || bus.sync) ? S_FLUSH : S_IDLE;
                end
            end
            S_MMIO: begin
                bus.stall = 1'b1;
                if (bus.mmu_l1_done) begin
                    mmio_wr = 1'b1;
                    state_d = S_MMIO_RESP;
                end
            end
            S_MMIO_RESP: begin
                bus.l1_data_o = mmio_buf_q;
                state_d       = (sync_pending_q || bus.sync) ? S_FLUSH : S_IDLE;
            end
            default: state_d = S_FLUSH;
        endcase
    end

    assign busy          = (state_q == S_REFILL) || (state_q == S_MMIO) || (state_q == S_MMIO_RESP);
    assign enter_flush   = (state_q != S_FLUSH) && (state_d == S_FLUSH);
    assign flush_restart = (state_d == S_FLUSH) && ((state_q != S_FLUSH) || bus.sync);

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            req_read_q     <= 1'b0;
            req_addr_q     <= '0;
            mmio_buf_q     <= '0;
            sync_pending_q <= 1'b0;
            flush_cnt_q    <= '0;
            miss_tag_q     <= '0;
            miss_idx_q     <= '0;
            miss_way_q     <= '0;
            for (int s = 0; s < SETS; s++) begin
                rr_q[s] <= '0;
            end
        end else begin
            if (start_refill) begin
                req_read_q <= 1'b1;
                req_addr_q <= {lu_tag, lu_idx, {OFF_W{1'b0}}};
                miss_tag_q <= lu_tag;
                miss_idx_q <= lu_idx;
                miss_way_q <= victim_way;
            end else if (start_mmio) begin
                req_read_q <= 1'b1;
                req_addr_q <= bus.l1_addr;
            end else if (refill_wr || mmio_wr) begin
                req_read_q <= 1'b0;
            end
            if (mmio_wr) begin
                mmio_buf_q <= bus.mmu_l1_read_data[31:0];
            end
            if (refill_wr) begin
                rr_q[miss_idx_q] <= (rr_q[miss_idx_q] == WAY_W'(WAYS - 1)) ? '0
                                                                          : rr_q[miss_idx_q] + 1'b1;
            end
            // A sync that lands mid-transaction is remembered until the cache is back at rest.
            if (enter_flush) begin
                sync_pending_q <= 1'b0;
            end else if (bus.sync && busy) begin
                sync_pending_q <= 1'b1;
            end
            if (flush_restart) begin
                flush_cnt_q <= '0;
            end else if (state_q == S_FLUSH) begin
                flush_cnt_q <= flush_cnt_q + 1'b1;
            end
        end
    end

    // Tag/data arrays are never reset; the flush walk clears every valid bit after reset.
    always_ff @(posedge sys_clk) begin
        if (!rst) begin
            if (state_q == S_FLUSH) begin
                for (int w = 0; w < WAYS; w++) begin
                    valid_q[w][flush_cnt_q] <= 1'b0;
                end
            end
            if (refill_wr) begin
                valid_q[miss_way_q][miss_idx_q] <= 1'b1;
                tag_q[miss_way_q][miss_idx_q]   <= miss_tag_q;
                data_q[miss_way_q][miss_idx_q]  <= bus.mmu_l1_read_data;
            end
        end
    end

    assign bus.l1_mmu_req_read = req_read_q;
    assign bus.l1_mmu_req_addr = req_addr_q;

    always_ff @(posedge sys_clk) begin
        if (!rst && (state_q == S_IDLE) && bus.l1_read && !bus.l1_is_mmio) begin
            assert ($onehot0(way_match));
        end
    end
endmodule
